// File: rtl/sixty_four_bit_serial_subtractor.sv
// sixty_four_bit_serial_subtractor
// Computes a + ~b + c_in over four cycles, one 16-bit slice per cycle,
// rippling the slice carry through a register between cycles.
// Optional: define SUB_FLAGS_EN to produce the n/z/v flags; otherwise
// they are tied low.
module sixty_four_bit_serial_subtractor (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c_in,
    output logic [63:0] diff,
    output logic        c_out,
    output logic        n,
    output logic        z,
    output logic        v,
    output logic        busy,
    output logic        done
);

    localparam int NUM_SLICES = 4;
    localparam int SLICE_W    = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                              state;
    logic [1:0]                          idx;
    logic [NUM_SLICES-1:0][SLICE_W-1:0]  a_q;
    logic [NUM_SLICES-1:0][SLICE_W-1:0]  b_q;
    logic [NUM_SLICES-1:0][SLICE_W-1:0]  diff_q;
    logic [NUM_SLICES-1:0][SLICE_W-1:0]  diff_next;
    logic                                carry_q;
    logic                                c_out_q;
    logic                                busy_q;
    logic                                done_q;
    logic [SLICE_W:0]                    slice_sum;

    // Current slice adder and the full result as it will look once this slice lands.
    always_comb begin
        slice_sum      = {1'b0, a_q[idx]} + {1'b0, ~b_q[idx]} + {{SLICE_W{1'b0}}, carry_q};
        diff_next      = diff_q;
        diff_next[idx] = slice_sum[SLICE_W-1:0];
    end

`ifdef SUB_FLAGS_EN
    logic n_q, z_q, v_q;

    // Flags are evaluated from the final result on the last slice, using latched operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else if (state == RUN && idx == 2'd3) begin
            n_q <= diff_next[3][SLICE_W-1];
            z_q <= (diff_next == '0);
            v_q <= (a_q[3][SLICE_W-1] != b_q[3][SLICE_W-1]) &
                   (diff_next[3][SLICE_W-1] != a_q[3][SLICE_W-1]);
        end
    end

    assign n = n_q;
    assign z = z_q;
    assign v = v_q;
`else
    assign n = 1'b0;
    assign z = 1'b0;
    assign v = 1'b0;
`endif

    // Control FSM plus operand/result registers; reset aborts any run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= c_in;
                        idx     <= 2'd0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    diff_q  <= diff_next;
                    carry_q <= slice_sum[SLICE_W];
                    idx     <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        c_out_q <= slice_sum[SLICE_W];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign diff  = diff_q;
    assign c_out = c_out_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/sixty_four_bit_serial_subtractor.md
SIXTY_FOUR_BIT_SERIAL_SUBTRACTOR -- requirements
Module: sixty_four_bit_serial_subtractor

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have: start  input  1  request to begin a subtraction; sampled only when not busy.
REQ-004 SHALL have: a  input  64  minuend, captured when start is accepted.
REQ-005 SHALL have: b  input  64  subtrahend, captured when start is accepted.
REQ-006 SHALL have: c_in  input  1  carry-in (1 = no borrow-in, plain SUB; 0 = SBC borrow), captured with a/b.
REQ-007 SHALL have: diff  output  64  result a + ~b + c_in, registered.
REQ-008 SHALL have: c_out  output  1  carry-out of bit 63 (1 = no borrow), registered.
REQ-009 SHALL have: n, z, v  output  1 each  negative, zero and signed-overflow flags, registered.
REQ-010 SHALL have: busy  output  1  high while slices are being computed.
REQ-011 SHALL have: done  output  1  single-cycle pulse marking a valid result.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE and a 2-bit slice index idx.
REQ-013 SHALL, in IDLE or DONE with start=1, latch a, b, c_in, set idx=0, enter RUN; start is ignored in RUN.
REQ-014 SHALL, each RUN cycle, compute 16-bit slice idx as a[16*idx+15:16*idx] + ~b[same] + carry and write it to diff[16*idx+15:16*idx].
REQ-015 SHALL use latched c_in as carry for slice 0 and the registered carry-out of slice idx-1 for slices 1..3.
REQ-016 SHALL increment idx after each slice; after slice 3, enter DONE; idx wraps 3->0.
REQ-017 SHALL have latency: start sampled at edge k -> done=1 and results valid after edge k+4.
REQ-018 SHALL assert done for exactly one cycle in DONE; DONE returns to IDLE next cycle unless start=1 (back-to-back start accepted, done still 1 for that cycle).
REQ-019 SHALL assert busy exactly while state is RUN.
REQ-020 SHALL hold diff, c_out, n, z, v stable from done until the next accepted start; partial slices may be visible in diff during RUN.
REQ-021 SHALL set c_out = carry from slice 3; v = (a[63] != b[63]) & (diff[63] != a[63]) using latched operands.
REQ-022 SHALL leave operand registers unaffected by changes on a, b, c_in during RUN.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, force state=IDLE, idx=0, diff=0, c_out=0, n=0, z=0, v=0, busy=0, done=0.
REQ-024 SHALL abort an in-progress RUN on reset with no done pulse; reset has priority over start.

Configuration
REQ-025 SHALL, with macro SUB_FLAGS_EN defined, compute n=diff[63], z=(diff==0), v per REQ-021 on entry to DONE.
REQ-026 SHALL, without SUB_FLAGS_EN, tie n, z, v to 0; diff, c_out, busy, done unchanged.

Verification
REQ-027 SHALL cover: a=5, b=3, c_in=1 -> 4 cycles later done=1, diff=2, c_out=1, n=0, z=0, v=0.
REQ-028 SHALL cover: a=0, b=1, c_in=1 -> diff=0xFFFFFFFFFFFFFFFF, c_out=0, n=1 (flags on).
REQ-029 SHALL cover: a=0x0000000000010000, b=1, c_in=1 -> diff=0x000000000000FFFF, c_out=1 (borrow ripples slice 0->1).
REQ-030 SHALL cover: a=0x8000000000000000, b=1, c_in=1 -> diff=0x7FFFFFFFFFFFFFFF, v=1, c_out=1; a=b=0x123456789ABCDEF0 -> diff=0, z=1, c_out=1.
REQ-031 SHALL cover: start at idx=2 with new operands ignored, result matches first operands; back-to-back start in DONE yields second done 4 cycles later.
REQ-032 SHALL cover: reset asserted at idx=1 -> next cycle all outputs 0, state IDLE, no done pulse.
